// File: rtl/icache_block_param_pkg.sv
// Shared types and helpers for the parametrised instruction cache:
// miss-FSM state encoding, geometry width functions and tree pseudo-LRU math.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // PLRU helpers work on a fixed maximum tree so they stay generic; callers
  // zero-extend their WAYS-1 bits in and slice the result back out.
  localparam int MAX_WAY_W = 6;
  localparam int MAX_NODES = (1 << MAX_WAY_W) - 1;

  typedef logic [MAX_NODES-1:0] plru_bits_t;
  typedef logic [MAX_WAY_W-1:0] way_idx_t;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int way_w(input int ways);
    return $clog2(ways);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int offs_w);
    return addr_w - $clog2(sets) - offs_w;
  endfunction

  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper
  // half). A bit of 1 means the victim lies in the upper half. An access makes
  // every node on its path point away from the accessed way.
  function automatic plru_bits_t plru_update(input plru_bits_t bits, input way_idx_t way,
                                             input int levels);
    plru_bits_t nb;
    way_idx_t   node;
    way_idx_t   aligned;
    logic       dir;
    nb      = bits;
    node    = '0;
    aligned = way << (MAX_WAY_W - levels);
    for (int lvl = 0; lvl < MAX_WAY_W; lvl++) begin
      if (lvl < levels) begin
        dir      = aligned[MAX_WAY_W-1];
        aligned  = aligned << 1;
        nb[node] = ~dir;
        node     = {node[MAX_WAY_W-2:0], 1'b0} + 6'd1 + {5'd0, dir};
      end else begin
        dir = 1'b0;
      end
    end
    return nb;
  endfunction

  // Follow the pointers from the root down to a leaf.
  function automatic way_idx_t plru_victim(input plru_bits_t bits, input int levels);
    way_idx_t v;
    way_idx_t node;
    logic     dir;
    v    = '0;
    node = '0;
    for (int lvl = 0; lvl < MAX_WAY_W; lvl++) begin
      if (lvl < levels) begin
        dir  = bits[node];
        v    = {v[MAX_WAY_W-2:0], dir};
        node = {node[MAX_WAY_W-2:0], 1'b0} + 6'd1 + {5'd0, dir};
      end else begin
        dir = 1'b0;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/icache_block_param_plru_tree.sv
// Tree pseudo-LRU for one set: next-state bits for an access and the current
// victim way. Supports WAYS from 2 up to 32.
module plru_tree
  import icache_pkg::*;
#(
  parameter int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  bits_i,
  input  logic [WAY_W-1:0] access_way_i,
  output logic [WAYS-2:0]  next_bits_o,
  output logic [WAY_W-1:0] victim_o
);

  plru_bits_t bits_ext_s;
  plru_bits_t next_ext_s;
  way_idx_t   way_ext_s;
  way_idx_t   victim_ext_s;
  logic       unused_ext_s;

  // Widen to the generic tree, evaluate both helpers, and narrow back.
  always_comb begin
    bits_ext_s                = '0;
    bits_ext_s[WAYS-2:0]      = bits_i;
    way_ext_s                 = '0;
    way_ext_s[WAY_W-1:0]      = access_way_i;
    next_ext_s                = plru_update(bits_ext_s, way_ext_s, WAY_W);
    victim_ext_s              = plru_victim(bits_ext_s, WAY_W);
  end

  assign next_bits_o  = next_ext_s[WAYS-2:0];
  assign victim_o     = victim_ext_s[WAY_W-1:0];
  assign unused_ext_s = ^{next_ext_s[MAX_NODES-1:WAYS-1], victim_ext_s[MAX_WAY_W-1:WAY_W]};

endmodule

// File: rtl/icache_block_param.sv
// N-way set-associative read-only instruction cache with one word per line,
// tree pseudo-LRU replacement, request/grant miss fill and snoop invalidate.
module icache_block_param
  import icache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int SETS   = 16,
  parameter int WAYS   = 4,
  parameter int OFFS_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     PrRd,
  input  logic [ADDR_W-1:0]        Address,
  inout  wire  [ADDR_W-1:0]        Data_Bus,
  output logic                     CPU_stall,
  output logic                     Com_Bus_Req_proc,
  input  logic                     Com_Bus_Gnt_proc,
  inout  wire  [ADDR_W-1:0]        Address_Com,
  input  logic [ADDR_W-1:0]        Data_Bus_Com,
  input  logic                     Data_in_Bus,
  input  logic                     Inv_req,
  input  logic [ADDR_W-1:0]        Inv_addr,
  output logic [$clog2(WAYS)-1:0]  Blk_accessed
);

  localparam int IDX_W  = idx_w(SETS);
  localparam int WAY_W  = way_w(WAYS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, OFFS_W);
  localparam int LINES  = SETS * WAYS;

  // Line storage, flat-indexed by {set, way}.
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [ADDR_W-1:0] data_q [LINES];
  logic [WAYS-2:0]   plru_q [SETS];

  state_e            state_q;
  logic              req_q;
  logic [WAY_W-1:0]  blk_q;
  logic [TAG_W-1:0]  fill_tag_q;
  logic [IDX_W-1:0]  fill_idx_q;
  logic [WAY_W-1:0]  victim_q;

  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic [IDX_W-1:0]  snp_idx_s;
  logic [TAG_W-1:0]  snp_tag_s;
  logic [WAYS-1:0]   hit_vec_s;
  logic [WAYS-1:0]   snp_vec_s;
  logic              hit_s;
  logic [WAY_W-1:0]  hit_way_s;
  logic [ADDR_W-1:0] hit_data_s;
  logic              free_any_s;
  logic [WAY_W-1:0]  free_way_s;
  logic [IDX_W-1:0]  plru_set_s;
  logic [WAY_W-1:0]  plru_way_s;
  logic [WAYS-2:0]   plru_next_s;
  logic [WAY_W-1:0]  plru_victim_s;
  logic [WAY_W-1:0]  victim_sel_s;
  logic              unused_addr_s;

  assign idx_s     = Address[OFFS_W+IDX_W-1:OFFS_W];
  assign tag_s     = Address[ADDR_W-1:OFFS_W+IDX_W];
  assign snp_idx_s = Inv_addr[OFFS_W+IDX_W-1:OFFS_W];
  assign snp_tag_s = Inv_addr[ADDR_W-1:OFFS_W+IDX_W];
  assign unused_addr_s = ^{Address[OFFS_W-1:0], Inv_addr[OFFS_W-1:0]};

  // Parallel tag compare for the fetch and snoop ports, plus lowest free way.
  always_comb begin
    hit_vec_s  = '0;
    snp_vec_s  = '0;
    hit_way_s  = '0;
    hit_data_s = '0;
    free_any_s = 1'b0;
    free_way_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec_s[w] = valid_q[{idx_s, WAY_W'(w)}] && (tag_q[{idx_s, WAY_W'(w)}] == tag_s);
      snp_vec_s[w] = valid_q[{snp_idx_s, WAY_W'(w)}] &&
                     (tag_q[{snp_idx_s, WAY_W'(w)}] == snp_tag_s);
      if (hit_vec_s[w]) begin
        hit_way_s  = WAY_W'(w);
        hit_data_s = data_q[{idx_s, WAY_W'(w)}];
      end else begin
        hit_way_s  = hit_way_s;
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[{idx_s, WAY_W'(w)}]) begin
        free_any_s = 1'b1;
        free_way_s = WAY_W'(w);
      end else begin
        free_any_s = free_any_s;
      end
    end
  end

  assign hit_s = |hit_vec_s;

  // PLRU port serves the fetch set in IDLE and the latched fill set in FILL.
  always_comb begin
    if (state_q == ST_FILL) begin
      plru_set_s = fill_idx_q;
      plru_way_s = victim_q;
    end else begin
      plru_set_s = idx_s;
      plru_way_s = hit_way_s;
    end
  end

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits_i       (plru_q[plru_set_s]),
    .access_way_i (plru_way_s),
    .next_bits_o  (plru_next_s),
    .victim_o     (plru_victim_s)
  );

  assign victim_sel_s = free_any_s ? free_way_s : plru_victim_s;

  assign CPU_stall        = PrRd && ((state_q != ST_IDLE) || !hit_s || Inv_req);
  assign Data_Bus         = (PrRd && !CPU_stall) ? hit_data_s : {ADDR_W{1'bz}};
  assign Address_Com      = (state_q == ST_FILL) ? {fill_tag_q, fill_idx_q, {OFFS_W{1'b0}}}
                                                 : {ADDR_W{1'bz}};
  assign Com_Bus_Req_proc = req_q;
  assign Blk_accessed     = blk_q;

  // Miss FSM, PLRU/valid maintenance and line fill; a fill write is ordered
  // after the snoop clear so a fill always wins on the same line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      blk_q      <= '0;
      valid_q    <= '0;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      victim_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
      end
    end else begin
      if (Inv_req) begin
        for (int w = 0; w < WAYS; w++) begin
          if (snp_vec_s[w]) begin
            valid_q[{snp_idx_s, WAY_W'(w)}] <= 1'b0;
          end else begin
            valid_q[{snp_idx_s, WAY_W'(w)}] <= valid_q[{snp_idx_s, WAY_W'(w)}];
          end
        end
      end else begin
        valid_q <= valid_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (PrRd && !Inv_req) begin
            if (hit_s) begin
              plru_q[idx_s] <= plru_next_s;
              blk_q         <= hit_way_s;
            end else begin
              fill_tag_q <= tag_s;
              fill_idx_q <= idx_s;
              victim_q   <= victim_sel_s;
              req_q      <= 1'b1;
              state_q    <= ST_REQ;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (Com_Bus_Gnt_proc) begin
            state_q <= ST_FILL;
          end else begin
            state_q <= ST_REQ;
          end
        end
        ST_FILL: begin
          if (Data_in_Bus) begin
            valid_q[{fill_idx_q, victim_q}] <= 1'b1;
            tag_q[{fill_idx_q, victim_q}]   <= fill_tag_q;
            data_q[{fill_idx_q, victim_q}]  <= Data_Bus_Com;
            plru_q[fill_idx_q]              <= plru_next_s;
            blk_q                           <= victim_q;
            req_q                           <= 1'b0;
            state_q                         <= ST_DONE;
          end else if (!Com_Bus_Gnt_proc) begin
            state_q <= ST_REQ;
          end else begin
            state_q <= ST_FILL;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_block_param.sv
// Directed plus randomized bench for icache_block_param (default geometry:
// 32-bit address, 16 sets, 4 ways, 2 offset bits) against a recency-based model.
module tb_icache_block_param;

  localparam logic [31:0] ZV = 32'hFFFF_FFFF;  // undriven tri1 net reads all ones

  logic        clk = 1'b0;
  logic        rst, PrRd, gnt, din, inv_req;
  logic [31:0] addr, bus_com, inv_addr;
  tri1  [31:0] data_bus_w;
  tri1  [31:0] addr_com_w;
  logic        stall, req;
  logic [1:0]  blk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: contents per set/way and last-use timestamps.
  bit          m_valid [16][4];
  logic [25:0] m_tag   [16][4];
  logic [31:0] m_data  [16][4];
  int unsigned m_use   [16][4];
  int unsigned m_time;

  always #5 clk = ~clk;

  icache_block_param dut (
    .clk              (clk),
    .rst              (rst),
    .PrRd             (PrRd),
    .Address          (addr),
    .Data_Bus         (data_bus_w),
    .CPU_stall        (stall),
    .Com_Bus_Req_proc (req),
    .Com_Bus_Gnt_proc (gnt),
    .Address_Com      (addr_com_w),
    .Data_Bus_Com     (bus_com),
    .Data_in_Bus      (din),
    .Inv_req          (inv_req),
    .Inv_addr         (inv_addr),
    .Blk_accessed     (blk)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_reset();
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0;
        m_use[s][w]   = 0;
      end
    end
    m_time = 0;
  endfunction

  function automatic int m_lookup(input logic [31:0] a);
    int s;
    s = int'(a[5:2]);
    for (int w = 0; w < 4; w++) begin
      if (m_valid[s][w] && m_tag[s][w] == a[31:6]) return w;
    end
    return -1;
  endfunction

  // Lowest free way; otherwise at each tree level go to the half that does not
  // hold the most recent access made within the current range (left if none).
  function automatic int m_victim(input int s);
    int lo, size, half, best;
    int unsigned bt;
    for (int w = 0; w < 4; w++) begin
      if (!m_valid[s][w]) return w;
    end
    lo = 0;
    size = 4;
    while (size > 1) begin
      half = size / 2;
      best = -1;
      bt = 0;
      for (int w = lo; w < lo + size; w++) begin
        if (m_use[s][w] > bt) begin
          bt = m_use[s][w];
          best = w;
        end
      end
      if (best >= 0 && best < lo + half) lo = lo + half;
      size = half;
    end
    return lo;
  endfunction

  function automatic void m_invalidate(input logic [31:0] a);
    int w;
    w = m_lookup(a);
    if (w >= 0) m_valid[int'(a[5:2])][w] = 1'b0;
  endfunction

  // One complete fetch; bus responses follow the expected miss timeline.
  task automatic do_read(input logic [31:0] a, input int delay, input logic [31:0] fdata,
                         input bit inv_first, input bit early);
    int s, w, k, fill_k;
    bit exp_hit, done;
    logic [31:0] exp_data, exp_addr;
    logic exp_req;
    s = int'(a[5:2]);
    PrRd = 1'b1;
    addr = a;
    if (inv_first) begin
      inv_req = 1'b1;
      inv_addr = a;
      #4;
      check("inv_stall", 32'(stall), 32'd1);
      check("inv_data_z", data_bus_w, ZV);
      cycle();
      inv_req = 1'b0;
      m_invalidate(a);
    end
    w = m_lookup(a);
    exp_hit = (w >= 0);
    if (exp_hit) begin
      exp_data = m_data[s][w];
    end else begin
      w = m_victim(s);
      exp_data = fdata;
    end
    fill_k = delay + 2;
    k = 0;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      gnt = !exp_hit && (k >= delay + 1) && (k <= fill_k);
      din = !exp_hit && ((k == fill_k) || (early && k == delay + 1));
      bus_com = (k == fill_k) ? fdata : ~fdata;
      #4;
      if (!stall) begin
        check("hit_data", data_bus_w, exp_data);
        check("hit_req", 32'(req), 32'd0);
        done = 1'b1;
      end else begin
        if (!exp_hit && k <= fill_k + 1) begin
          exp_req  = (k >= 1 && k <= fill_k);
          exp_addr = (k == fill_k) ? {a[31:2], 2'b00} : ZV;
          check("stall_req", 32'(req), 32'(exp_req));
          check("stall_com_addr", addr_com_w, exp_addr);
          check("stall_data_z", data_bus_w, ZV);
        end
        k++;
      end
      cycle();
    end
    PrRd = 1'b0;
    gnt = 1'b0;
    din = 1'b0;
    check("read_done", 32'(done), 32'd1);
    check("stall_cycles", 32'(k), exp_hit ? 32'd0 : 32'(delay + 4));
    check("blk_accessed", 32'(blk), 32'(w));
    if (!exp_hit) begin
      m_valid[s][w] = 1'b1;
      m_tag[s][w]   = a[31:6];
      m_data[s][w]  = fdata;
    end
    m_time++;
    m_use[s][w] = m_time;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  sets_pool [3];
    sets_pool[0] = 4'd0;
    sets_pool[1] = 4'd1;
    sets_pool[2] = 4'd5;
    rst = 1'b1; PrRd = 1'b0; gnt = 1'b0; din = 1'b0; inv_req = 1'b0;
    addr = 32'd0; bus_com = 32'd0; inv_addr = 32'd0;
    m_reset();
    cycle();
    cycle();
    rst = 1'b0;
    #4;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(req), 32'd0);
    check("rst_blk", 32'(blk), 32'd0);
    check("rst_data_z", data_bus_w, ZV);
    check("rst_com_addr_z", addr_com_w, ZV);
    cycle();

    // Cold miss, then hit on the same line.
    do_read(32'h0000_0040, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("cold_blk_way0", 32'(blk), 32'd0);
    do_read(32'h0000_0040, 0, 32'h0, 1'b0, 1'b0);

    // Fill set 0, touch way 0, then evict: victim is way 2.
    do_read(32'h0000_0080, 0, 32'h1111_0080, 1'b0, 1'b0);
    do_read(32'h0000_00C0, 0, 32'h2222_00C0, 1'b0, 1'b1);
    do_read(32'h0000_0100, 1, 32'h3333_0100, 1'b0, 1'b0);
    check("fill_way3", 32'(blk), 32'd3);
    do_read(32'h0000_0040, 0, 32'h0, 1'b0, 1'b0);
    do_read(32'h0000_0140, 0, 32'h4444_0140, 1'b0, 1'b0);
    check("evict_way2", 32'(blk), 32'd2);

    // Delayed grant.
    do_read(32'h0000_0244, 10, 32'h5555_0244, 1'b0, 1'b0);

    // Invalidate concurrent with a hit: stalled, then refetched.
    do_read(32'h0000_0040, 0, 32'h6666_0040, 1'b1, 1'b0);

    // Reset while in FILL.
    PrRd = 1'b1; addr = 32'h0000_0380;
    #4; check("rf_miss_stall", 32'(stall), 32'd1);
    cycle();
    gnt = 1'b1;
    #4; check("rf_req", 32'(req), 32'd1);
    cycle();
    #4; check("rf_fill_addr", addr_com_w, 32'h0000_0380);
    rst = 1'b1; PrRd = 1'b0;
    cycle();
    rst = 1'b0; gnt = 1'b0;
    #4;
    check("rf_req_drop", 32'(req), 32'd0);
    check("rf_com_addr_z", addr_com_w, ZV);
    check("rf_blk", 32'(blk), 32'd0);
    cycle();
    m_reset();
    do_read(32'h0000_0380, 0, 32'h7777_0380, 1'b0, 1'b0);
    do_read(32'h0000_0040, 0, 32'h8888_0040, 1'b0, 1'b0);

    // Randomized traffic over a few crowded sets.
    for (int i = 0; i < 80; i++) begin
      a = {26'($urandom_range(1, 6)), sets_pool[$urandom_range(0, 2)], 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) < 2) begin
        inv_req = 1'b1;
        inv_addr = a;
        #4;
        check("snoop_only_stall", 32'(stall), 32'd0);
        cycle();
        inv_req = 1'b0;
        m_invalidate(a);
      end else begin
        do_read(a, int'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 1) == 1));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache_block_param.md
# icache_block_param

Parametrised, N-way set-associative, read-only instruction cache block, successor to the fixed 4-way instruction cache. It serves one processor's fetch port and sits on the shared instruction common bus. Misses are filled through the common arbiter using a request/grant handshake. Unlike the 4-way block, it has synchronous reset of all tag state, an internal tree pseudo-LRU, a proper miss FSM, and a snoop line-invalidate port.

## Interface
Parameters:
- ADDR_W, 32, address and data width (one word per line)
- SETS, 16, number of sets; power of 2, ≥2
- WAYS, 4, associativity; power of 2, ≥2
- OFFS_W, 2, byte-offset bits ignored for indexing

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- PrRd  in  1  processor fetch request, held until CPU_stall=0
- Address  in  ADDR_W  fetch address
- Data_Bus  inout  ADDR_W  instruction to CPU; driven only when PrRd && !CPU_stall, else Z
- CPU_stall  out  1  stall to processor
- Com_Bus_Req_proc  out  1  request to common arbiter
- Com_Bus_Gnt_proc  in  1  grant from arbiter
- Address_Com  inout  ADDR_W  line address on common bus; driven only in FILL, else Z
- Data_Bus_Com  in  ADDR_W  fill data from L2 or a peer cache
- Data_in_Bus  in  1  fill data valid on Data_Bus_Com
- Inv_req  in  1  snoop invalidate strobe
- Inv_addr  in  ADDR_W  address to invalidate
- Blk_accessed  out  $clog2(WAYS)  way of the most recent hit or fill

## Operation
- Address split: offset [OFFS_W-1:0], index [OFFS_W+IDX_W-1:OFFS_W], and the remaining upper bits as the tag. IDX_W = $clog2(SETS).
- Storage per line: valid bit, tag, data word. Per set: WAYS-1 tree-PLRU bits.
- Lookup is combinational over all ways. A hit requires valid && tag match. At most one way matches.
- FSM states: IDLE, REQ, FILL, DONE.
  - IDLE: if PrRd and hit, return data with CPU_stall=0, update PLRU toward the hit way, and set Blk_accessed. If PrRd and miss, latch the address and choose the victim, then go to REQ.
  - Victim choice: the lowest-index invalid way; otherwise the PLRU victim.
  - REQ: Com_Bus_Req_proc=1. On Com_Bus_Gnt_proc=1, go to FILL.
  - FILL: Com_Bus_Req_proc=1, and Address_Com = {latched tag, index, OFFS_W'b0}. On Data_in_Bus=1, write data, tag and valid into the victim, update PLRU, set Blk_accessed, and go to DONE.
  - FILL, grant lost: if grant drops before Data_in_Bus, return to REQ. The line is not written.
  - DONE: Com_Bus_Req_proc=0. Go to IDLE. The next cycle re-looks-up and hits.
- CPU_stall = PrRd && (state != IDLE || miss || Inv_req).
- Invalidate: in any state, Inv_req clears the valid bit of the matching line at the edge.
  - Inv_req has priority over a same-cycle hit, which is stalled for that cycle.
  - If an invalidate matches the line being filled during FILL, the fill still completes. Coherence for instruction lines is handled by software.
- If Address changes while stalled, that is a protocol violation. The fill uses the latched address.

## Timing
- Reset values: CPU_stall=0, Com_Bus_Req_proc=0, Blk_accessed=0, Data_Bus=Z, Address_Com=Z, state=IDLE. All valid and PLRU bits are 0; data and tag contents are don't-care.
- Reset mid-fill: the FSM returns to IDLE on the next edge, the request is dropped, and no line is written.
- Hit latency: 0 cycles. Data is valid in the same cycle as PrRd.
- Miss latency with immediate grant and data: miss cycle (IDLE→REQ), REQ, FILL (data), DONE, then the hit in IDLE. That is 4 stall cycles.
- Com_Bus_Req_proc stays high from REQ entry through the FILL data cycle and drops in DONE.
- Gnt and Data_in_Bus in the same REQ cycle: Data_in_Bus is ignored until FILL.

## Structure
- Package icache_pkg holds:
  - the state enum (IDLE, REQ, FILL, DONE);
  - width functions for IDX_W, TAG_W and WAY_W;
  - the PLRU update and victim functions.
- Sub-module plru_tree(WAYS): combinational next-bits for an access, plus victim selection.
- Tag and data arrays are flat regs indexed by {index, way}.

## Test plan
- Cold miss:
  - Stimulus: after reset, PrRd at 0x0000_0040 with immediate grant; Data_in_Bus with 0xDEAD_BEEF on the FILL cycle.
  - Expected: Address_Com=0x40, 4 stall cycles, then Data_Bus=0xDEAD_BEEF and Blk_accessed=0.
- Hit after fill:
  - Stimulus: repeat the read of 0x40.
  - Expected: CPU_stall=0 and data in the same cycle; Com_Bus_Req_proc stays 0.
- Set fill and eviction (WAYS=4):
  - Stimulus: fill 5 tags into set 0 with fills to ways 0,1,2,3, then read way 0 again and miss a 5th tag.
  - Expected: fills land in ways 0,1,2,3; the 5th replaces the PLRU victim, way 2.
- Delayed grant:
  - Stimulus: hold Gnt=0 for 10 cycles.
  - Expected: Com_Bus_Req_proc=1 and CPU_stall=1 throughout, Address_Com=Z, and the fill completes after the grant.
- Invalidate:
  - Stimulus: Inv_req at 0x40, simultaneous with PrRd 0x40.
  - Expected: that cycle is stalled, the next cycle misses and refetches.
- Reset mid-FILL:
  - Stimulus: assert rst for 1 cycle during FILL.
  - Expected: req=0, Address_Com=Z, and a later read of the same address misses.
